// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand widths, op encodings and the legality check
// used by everything that drives the shared combinational ALU.
package alu_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1101;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0111;

    // True for the ten op codes the ALU implements; anything else is flagged.
    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping modulo N. Output is one-hot (or zero when en is low or
// nothing requests) plus the encoded winner index.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] pos;
    int               sum;

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        sum   = 0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            pos = IDX_W'(sum);
            if (en && !found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters. One op is accepted
// per cycle; its result is captured in a single-entry response register
// tagged with the requester index.
//
// Handshakes: a request transfers on the rising edge where req_valid[i] and
// req_ready[i] are both high; a response transfers where resp_valid and
// resp_ready are both high. Producers hold their payload stable while valid
// until it transfers, and valid never depends on ready.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [XLEN*NUM_REQ-1:0]   req_a,
    input  logic [XLEN*NUM_REQ-1:0]   req_b,
    input  logic [ALU_OP_W*NUM_REQ-1:0] req_op,
    output logic [XLEN-1:0]           alu_a,
    output logic [XLEN-1:0]           alu_b,
    output logic [ALU_OP_W-1:0]       alu_op,
    input  logic [XLEN-1:0]           alu_result,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [XLEN-1:0]           resp_result,
    output logic                      resp_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   prio_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   gnt_idx;
    logic               can_issue;
    logic               arb_en;
    logic               transfer;

    // The response slot is free when empty or being drained this cycle.
    // Holding the arbiter off during reset keeps req_ready low then.
    assign can_issue = !resp_valid || resp_ready;
    assign arb_en    = can_issue && rst_n;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (prio_ptr),
        .en    (arb_en),
        .grant (grant),
        .idx   (gnt_idx)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    // Steer the granted requester's operands to the ALU; idle lines are zero.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_a  = req_a[i*XLEN +: XLEN];
                alu_b  = req_b[i*XLEN +: XLEN];
                alu_op = req_op[i*ALU_OP_W +: ALU_OP_W];
            end
        end
    end

    // Response register and priority pointer: load on a grant (overwriting a
    // draining entry with no bubble), otherwise clear valid on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            prio_ptr    <= '0;
        end else if (transfer) begin
            resp_valid  <= 1'b1;
            resp_id     <= ID_W'(gnt_idx);
            resp_result <= alu_op_legal(alu_op) ? alu_result : '0;
            resp_err    <= !alu_op_legal(alu_op);
            prio_ptr    <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with three requesters and a behavioural ALU. A model
// process predicts grants and pushes expected responses; a monitor pops them.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N  = 3;
    localparam int IW = 2;
    localparam int EW = IW + 1 + 32;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [4*N-1:0]    req_op;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [3:0]        alu_op;
    logic [31:0]       alu_result;
    logic              resp_valid;
    logic              resp_ready;
    logic [IW-1:0]     resp_id;
    logic [31:0]       resp_result;
    logic              resp_err;

    logic [3:0]        op_s[N];
    logic [31:0]       a_s[N];
    logic [31:0]       b_s[N];
    logic [N-1:0]      keep;

    logic [EW-1:0]     exp_q[$];
    int                m_ptr;
    bit                m_held;
    logic [N-1:0]      acc_mask;
    int                n_cmp;
    int                n_err;

    alu_arbiter #(
        .NUM_REQ (N),
        .ID_W    (IW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; unknown codes give a non-zero junk value.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        logic [31:0] r;
        case (op)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << b[4:0];
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b1101: r = 32'($signed(a) >>> b[4:0]);
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = 32'hdeadbeef;
        endcase
        return r;
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = a_s[i];
            req_b[32*i +: 32] = b_s[i];
            req_op[4*i +: 4]  = op_s[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Grant = first valid requester from the pointer upward, only when the
    // response slot is empty or draining. Runs after the monitor each cycle.
    always @(negedge clk) begin
        int      g;
        int      j;
        bit      found;
        bit      can;
        bit      legal;
        logic [31:0] res;
        logic [N-1:0] exp_g;
        #2;
        if (!rst_n) begin
            m_ptr    = 0;
            m_held   = 0;
            acc_mask = '0;
        end else begin
            can   = !m_held || resp_ready;
            found = 0;
            g     = 0;
            exp_g = '0;
            if (can) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!found && req_valid[j]) begin
                        found = 1;
                        g     = j;
                    end
                end
            end
            if (found) exp_g[g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_g));
            check("alu_a", 64'(alu_a), found ? 64'(a_s[g]) : 64'd0);
            check("alu_b", 64'(alu_b), found ? 64'(b_s[g]) : 64'd0);
            check("alu_op", 64'(alu_op), found ? 64'(op_s[g]) : 64'd0);
            if (found) begin
                legal = op_s[g] inside {4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hd, 4'h6, 4'h7};
                res   = legal ? alu_fn(a_s[g], b_s[g], op_s[g]) : 32'd0;
                exp_q.push_back({IW'(g), !legal, res});
                m_ptr  = (g + 1) % N;
                m_held = 1;
            end else if (resp_ready) begin
                m_held = 0;
            end
            acc_mask = exp_g;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("resp_valid", 64'(resp_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                if (resp_valid) begin
                    check("resp_id", 64'(resp_id), 64'(e[EW-1 -: IW]));
                    check("resp_err", 64'(resp_err), 64'(e[32]));
                    check("resp_result", 64'(resp_result), 64'(e[31:0]));
                end
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit k);
        op_s[i]      = op;
        a_s[i]       = a;
        b_s[i]       = b;
        keep[i]      = k;
        req_valid[i] = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i] && !keep[i]) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic stop_all();
        keep      = '0;
        req_valid = '0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (req_valid != '0 && c < 60) begin
            tick(1);
            c++;
        end
        if (req_valid != '0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: pending %0b expected 0", req_valid);
            stop_all();
        end
        resp_ready = 1'b1;
        tick(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        check({tag, "_resp_result"}, 64'(resp_result), 64'd0);
        check({tag, "_resp_err"}, 64'(resp_err), 64'd0);
        check({tag, "_alu_lines"}, 64'({alu_a, alu_op}), 64'd0);
    endtask

    // Watchdog: never let the run hang.
    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp      = 0;
        n_err      = 0;
        keep       = '0;
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            op_s[i] = ALU_ADD;
            a_s[i]  = 32'h1 + 32'(i);
            b_s[i]  = 32'h2;
        end
        req_valid = '1;

        // Reset values while held in reset with requests present.
        #12;
        check_reset_outputs("in_reset");
        req_valid = '0;
        @(posedge clk);
        #4 rst_n = 1'b1;

        // 1: single add.
        set_req(0, ALU_ADD, 32'h7fffffff, 32'h00000001, 0);
        wait_idle();

        // 2: alternation between sub and sra.
        set_req(0, ALU_SUB, 32'h0, 32'h1, 1);
        set_req(1, ALU_SRA, 32'hffffff00, 32'h4, 1);
        tick(8);
        stop_all();
        tick(2);

        // 3: backpressure, then drain and load on the same edge.
        resp_ready = 1'b0;
        set_req(0, ALU_ADD, 32'h12345678, 32'h11111111, 0);
        tick(1);
        set_req(1, ALU_SLTU, 32'h80000000, 32'h1, 0);
        tick(5);
        resp_ready = 1'b1;
        wait_idle();

        // 4: illegal op followed by sll.
        set_req(0, 4'b1111, 32'h5, 32'h3, 0);
        tick(1);
        set_req(0, ALU_SLL, 32'hffffff00, 32'h24, 0);
        wait_idle();

        // 5: asynchronous reset while a response is held.
        set_req(1, ALU_XOR, 32'h0f0f0f0f, 32'hffff0000, 0);
        tick(1);
        resp_ready = 1'b0;
        tick(2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        set_req(0, ALU_OR, 32'h00f0, 32'h0f00, 1);
        set_req(1, ALU_AND, 32'hff00ff00, 32'h0ff00ff0, 1);
        set_req(2, ALU_SLT, 32'hffffffff, 32'h1, 1);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        resp_ready = 1'b1;
        tick(6);
        stop_all();
        tick(2);

        // 6: only req0 and req2, then req1 joins.
        set_req(0, ALU_SRL, 32'h80000000, 32'h1f, 1);
        set_req(2, ALU_SUB, 32'h10, 32'h20, 1);
        tick(6);
        set_req(1, ALU_ADD, 32'hffffffff, 32'hffffffff, 1);
        tick(9);
        stop_all();
        tick(2);

        // Random traffic with random consumer stalls.
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom, 0);
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        wait_idle();
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin controller that shares one combinational ALU between NUM_REQ requesters, for example the integer pipeline and a multi-cycle mul/div sequencer. It accepts one operation per cycle using valid/ready handshakes, drives the ALU operand and op lines, and registers the result into a single-entry response stage tagged with the requester id. Latency is 1 cycle; throughput is 1 op per cycle when the consumer does not stall.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, width of resp_id; must be at least clog2(NUM_REQ)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  32*NUM_REQ  operand a, requester i at bits [32i+31:32i]
req_b  in  32*NUM_REQ  operand b; shifts use b[4:0] only
req_op  in  4*NUM_REQ  ALU op code, requester i at bits [4i+3:4i]
alu_a  out  32  operand a to shared ALU
alu_b  out  32  operand b to shared ALU
alu_op  out  4  op to shared ALU
alu_result  in  32  combinational ALU result
resp_valid  out  1  response register holds data
resp_ready  in  1  consumer accepts the response
resp_id  out  ID_W  index of the requester that issued the op
resp_result  out  32  registered result
resp_err  out  1  op code was illegal

Behaviour:
- Legal op codes: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111. Every other code is illegal.
- can_issue = !resp_valid || resp_ready.
- Grant rule: pick the first i with req_valid[i], searching from prio_ptr upward and wrapping mod NUM_REQ. The grant is valid only when can_issue is high.
- req_ready[i] = grant[i]. This output is combinational from req_valid, resp_valid and resp_ready. A transfer happens when req_valid[i] && req_ready[i].
- ALU drive is combinational. On a grant, alu_a/alu_b/alu_op come from the granted requester. With no grant, they are 0/0/0000.
- On a transfer at edge N:
  - resp_valid=1 after edge N.
  - resp_result = alu_result, or 0 for an illegal op.
  - resp_err = 1 only for an illegal op.
  - resp_id = index of the granted requester.
  - prio_ptr = (granted index + 1) mod NUM_REQ.
- At an edge with resp_valid && resp_ready and no new grant: resp_valid goes to 0, and the other resp_* fields hold their values.
- Simultaneous drain and grant in the same cycle: the response register is overwritten with no bubble.
- Backpressure: while resp_valid && !resp_ready, req_ready is all zero and resp_* is stable. prio_ptr is unchanged.
- Requesters must hold req_* stable while valid until accepted. The arbiter does not enforce this.
- Reset, asynchronous at any time including mid-transfer:
  - resp_valid=0, resp_id=0, resp_result=0, resp_err=0, prio_ptr=0.
  - Any in-flight response is dropped.
  - req_ready is 0 while reset is asserted.
- No state besides the response register and prio_ptr. Implementation is about 150-250 lines.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit ALU op constants ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND;
  - the function alu_op_legal(op);
  - the widths XLEN=32 and ALU_OP_W=4.
- Sub-module rr_arbiter (parameter N) is natural: inputs req, ptr, en; outputs a one-hot grant and the encoded index. It is reusable for the register-file write port.
- The ALU itself is instantiated outside this block. The bench connects the existing ALU.

Test Plan:
1. Single request, reset values: after reset, req0 add a=7fffffff b=00000001, resp_ready=1 -> req_ready=01 in that cycle; next cycle resp_valid=1, resp_id=0, resp_result=80000000, resp_err=0. Also check all outputs are 0 while rst_n=0.
2. Alternation: both valid continuously, resp_ready=1. req0 sub a=0 b=1; req1 sra a=ffffff00 b=00000004 -> grants 0,1,0,1 with no bubbles; results ffffffff and fffffff0 alternate with ids 0,1.
3. Backpressure: resp_valid=1, resp_ready=0 for 5 cycles -> req_ready=00, resp_* stable; raise resp_ready -> the same edge drains and loads the next op (req1 sltu a=80000000 b=1 -> 00000000).
4. Illegal op: req0 op=1111 a=5 b=3 -> resp_valid=1, resp_err=1, resp_result=00000000; next legal op sll a=ffffff00 b=24 -> fffff000, resp_err=0.
5. Mid-operation reset: rst_n low asynchronously (not on an edge) while resp_valid=1 -> resp_valid drops immediately. After release, with req1 last granted and both valid, the first grant goes to req0.
6. NUM_REQ=3, only req0 and req2 valid -> grant order 0,2,0,2. Add req1 -> order 0,1,2 from the next pointer position.
